nxn_turn_ctrl: RTL and testbench

// - Parametrised turn/arbitration FSM for N x N, N-in-a-row board games with 2..4 players.
// - Accepts moves over a valid/ready handshake, rejects illegal moves, optionally forfeits slow turns.
// - Checks for a win one line per cycle and reports win/tie to the display and top-level glue.
// - Sits between the move-entry decoder (switches/keys) and the VGA/seven-segment board renderer.

---
 rtl/nxn_turn_ctrl_pkg.sv | 23 ++
 rtl/nxn_turn_ctrl_if.sv | 34 +++
 rtl/nxn_turn_ctrl_line_check.sv | 40 ++++
 rtl/nxn_turn_ctrl.sv | 177 +++++++++++++++++
 tb/tb_nxn_turn_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/nxn_turn_ctrl_pkg.sv
// Shared encodings for the N x N turn controller: FSM states, outcome codes
// and the number of lines that can form a win.
package nxn_turn_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitMove,
    StPlace,
    StScan,
    StAdvance,
    StDone
  } state_e;

  localparam logic [1:0] OutNone = 2'b00;
  localparam logic [1:0] OutWin  = 2'b01;
  localparam logic [1:0] OutTie  = 2'b10;

  // N rows, N columns and the two diagonals.
  function automatic int unsigned line_count(input int unsigned n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/nxn_turn_ctrl_if.sv
// Move-entry / board-display bundle between the key decoder, the turn
// controller and the renderer.
interface nxn_turn_ctrl_if #(
  parameter int unsigned N       = 3,
  parameter int unsigned PLAYERS = 2
);
  localparam int unsigned CELLS = N * N;
  localparam int unsigned IW    = $clog2(CELLS);
  localparam int unsigned CW    = $clog2(PLAYERS + 1);
  localparam int unsigned PW    = $clog2(PLAYERS);

  logic                  start;
  logic                  move_valid;
  logic [IW-1:0]         move_idx;
  logic                  move_ready;
  logic [PW-1:0]         cur_player;
  logic [CELLS*CW-1:0]   board;
  logic                  reject;
  logic                  timeout;
  logic [1:0]            outcome;
  logic [CW-1:0]         winner;
  logic                  done;

  modport master (
    output start, move_valid, move_idx,
    input  move_ready, cur_player, board, reject, timeout, outcome, winner, done
  );

  modport slave (
    input  start, move_valid, move_idx,
    output move_ready, cur_player, board, reject, timeout, outcome, winner, done
  );

endinterface

// File: rtl/nxn_turn_ctrl_line_check.sv
// Combinational check that every cell of one board line holds a given player
// code; lines are rows, then columns, then main and anti diagonal.
module nxn_turn_ctrl_line_check #(
  parameter int unsigned N  = 3,
  parameter int unsigned CW = 2,
  parameter int unsigned LW = 3
) (
  input  logic [N*N*CW-1:0] board,
  input  logic [LW-1:0]     line,
  input  logic [CW-1:0]     code,
  output logic              match
);

  always_comb begin
    int unsigned l;
    int unsigned row;
    int unsigned col;
    l     = 32'(line);
    row   = 0;
    col   = 0;
    match = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      if (l < N) begin
        row = l;
        col = i;
      end else if (l < 2 * N) begin
        row = i;
        col = l - N;
      end else if (l == 2 * N) begin
        row = i;
        col = i;
      end else begin
        row = i;
        col = N - 1 - i;
      end
      if (board[(row * N + col) * CW +: CW] != code) match = 1'b0;
    end
  end

endmodule

// File: rtl/nxn_turn_ctrl.sv
// Turn/arbitration FSM for N x N, N-in-a-row games: accepts moves, rejects
// illegal ones, optionally forfeits slow turns and scans one line per cycle.
module nxn_turn_ctrl
  import nxn_turn_ctrl_pkg::*;
#(
  parameter int unsigned N           = 3,
  parameter int unsigned PLAYERS     = 2,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input logic            clk,
  input logic            rst,
  nxn_turn_ctrl_if.slave bus
);

  localparam int unsigned CELLS = N * N;
  localparam int unsigned IW    = $clog2(CELLS);
  localparam int unsigned CW    = $clog2(PLAYERS + 1);
  localparam int unsigned PW    = $clog2(PLAYERS);
  localparam int unsigned LINES = line_count(N);
  localparam int unsigned LW    = $clog2(LINES);
  localparam int unsigned FW    = $clog2(CELLS + 1);
  localparam int unsigned TW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned TLAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  state_e              state_q, state_d;
  logic [CELLS*CW-1:0] board_q, board_d;
  logic [FW-1:0]       filled_q, filled_d;
  logic [LW-1:0]       line_q, line_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [PW-1:0]       cur_q, cur_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                reject_q, reject_d;
  logic                timeout_q, timeout_d;
  logic [1:0]          outcome_q, outcome_d;
  logic [CW-1:0]       winner_q, winner_d;

  logic [CW-1:0] code;
  logic [CW-1:0] sel_cell;
  logic          accept;
  logic          legal;
  logic          match;

  assign code     = CW'(cur_q) + CW'(1);
  assign sel_cell = CW'(board_q >> (32'(bus.move_idx) * CW));
  assign accept   = bus.move_valid && (state_q == StWaitMove);
  assign legal    = (32'(bus.move_idx) < CELLS) && (sel_cell == '0);

  nxn_turn_ctrl_line_check #(
    .N  (N),
    .CW (CW),
    .LW (LW)
  ) u_line_check (
    .board (board_q),
    .line  (line_q),
    .code  (code),
    .match (match)
  );

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    filled_d  = filled_q;
    line_d    = line_q;
    tmr_d     = tmr_q;
    cur_d     = cur_q;
    idx_d     = idx_q;
    outcome_d = outcome_q;
    winner_d  = winner_q;
    reject_d  = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d   = StWaitMove;
          board_d   = '0;
          filled_d  = '0;
          tmr_d     = '0;
          cur_d     = '0;
          outcome_d = OutNone;
          winner_d  = '0;
        end
      end
      StWaitMove: begin
        if (accept && legal) begin
          idx_d   = bus.move_idx;
          state_d = StPlace;
        end else begin
          reject_d = accept;
          // A legal accept in the final cycle beats the forfeit.
          if (TIMEOUT_CYC > 0 && tmr_q == TW'(TLAST)) begin
            timeout_d = 1'b1;
            state_d   = StAdvance;
          end else if (TIMEOUT_CYC > 0) begin
            tmr_d = tmr_q + TW'(1);
          end
        end
      end
      StPlace: begin
        board_d[32'(idx_q) * CW +: CW] = code;
        filled_d = filled_q + FW'(1);
        line_d   = '0;
        state_d  = StScan;
      end
      StScan: begin
        if (match) begin
          outcome_d = OutWin;
          winner_d  = code;
          state_d   = StDone;
        end else if (line_q == LW'(LINES - 1)) begin
          if (filled_q == FW'(CELLS)) begin
            outcome_d = OutTie;
            state_d   = StDone;
          end else begin
            state_d = StAdvance;
          end
        end else begin
          line_d = line_q + LW'(1);
        end
      end
      StAdvance: begin
        cur_d   = (cur_q == PW'(PLAYERS - 1)) ? '0 : cur_q + PW'(1);
        tmr_d   = '0;
        state_d = StWaitMove;
      end
      default: begin
        state_d   = StIdle;
        board_d   = '0;
        filled_d  = '0;
        line_d    = '0;
        tmr_d     = '0;
        cur_d     = '0;
        idx_d     = '0;
        outcome_d = OutNone;
        winner_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      board_q   <= '0;
      filled_q  <= '0;
      line_q    <= '0;
      tmr_q     <= '0;
      cur_q     <= '0;
      idx_q     <= '0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
      outcome_q <= OutNone;
      winner_q  <= '0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      filled_q  <= filled_d;
      line_q    <= line_d;
      tmr_q     <= tmr_d;
      cur_q     <= cur_d;
      idx_q     <= idx_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
      outcome_q <= outcome_d;
      winner_q  <= winner_d;
    end
  end

  assign bus.move_ready = (state_q == StWaitMove);
  assign bus.done       = (state_q == StDone);
  assign bus.cur_player = cur_q;
  assign bus.board      = board_q;
  assign bus.reject     = reject_q;
  assign bus.timeout    = timeout_q;
  assign bus.outcome    = outcome_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_nxn_turn_ctrl.sv
// Directed bench: 3x3/2-player games, 4x4/3-player anti-diagonal win and a
// 3x3 instance with a 16-cycle turn limit.
module tb_nxn_turn_ctrl;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_pass;

  nxn_turn_ctrl_if #(.N(3), .PLAYERS(2)) if3 ();
  nxn_turn_ctrl_if #(.N(4), .PLAYERS(3)) if4 ();
  nxn_turn_ctrl_if #(.N(3), .PLAYERS(2)) ift ();

  nxn_turn_ctrl #(.N(3), .PLAYERS(2), .TIMEOUT_CYC(0)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  nxn_turn_ctrl #(.N(4), .PLAYERS(3), .TIMEOUT_CYC(0)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  nxn_turn_ctrl #(.N(3), .PLAYERS(2), .TIMEOUT_CYC(16)) u_dutt (
    .clk (clk),
    .rst (rst),
    .bus (ift)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic wait_ready3(input string tag);
    int unsigned n = 0;
    while (!if3.move_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!if3.move_ready) check(tag, 64'(if3.move_ready), 64'd1);
  endtask

  task automatic wait_ready4(input string tag);
    int unsigned n = 0;
    while (!if4.move_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!if4.move_ready) check(tag, 64'(if4.move_ready), 64'd1);
  endtask

  task automatic move3(input int idx);
    wait_ready3("ready3");
    if3.move_idx   = 4'(idx);
    if3.move_valid = 1'b1;
    @(negedge clk);
    if3.move_valid = 1'b0;
  endtask

  task automatic move4(input int idx);
    wait_ready4("ready4");
    if4.move_idx   = 4'(idx);
    if4.move_valid = 1'b1;
    @(negedge clk);
    if4.move_valid = 1'b0;
  endtask

  task automatic wait_done4();
    int unsigned n = 0;
    while (!if4.done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic start3();
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int moves_win[5];
    int moves_tie[9];
    int moves_n4[10];
    moves_win = '{0, 3, 1, 4, 2};
    moves_tie = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    moves_n4  = '{3, 0, 1, 6, 4, 2, 9, 5, 7, 12};
    n_checks = 0;
    n_pass   = 0;
    clk = 1'b0;
    rst = 1'b1;
    if3.start = 1'b0; if3.move_valid = 1'b0; if3.move_idx = '0;
    if4.start = 1'b0; if4.move_valid = 1'b0; if4.move_idx = '0;
    ift.start = 1'b0; ift.move_valid = 1'b0; ift.move_idx = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_ready", 64'(if3.move_ready), 64'd0);
    check("rst_board", 64'(if3.board), 64'd0);
    check("rst_outcome", 64'(if3.outcome), 64'd0);
    check("rst_done", 64'(if3.done), 64'd0);
    check("rst_cur", 64'(if3.cur_player), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Row-0 win by player 0, found on line 0 two edges after the accept.
    start3();
    check("start_ready", 64'(if3.move_ready), 64'd1);
    foreach (moves_win[i]) move3(moves_win[i]);
    @(negedge clk);
    check("win_lat_early", 64'(if3.done), 64'd0);
    @(negedge clk);
    check("win_done", 64'(if3.done), 64'd1);
    check("win_outcome", 64'(if3.outcome), 64'd1);
    check("win_winner", 64'(if3.winner), 64'd1);
    check("win_ready", 64'(if3.move_ready), 64'd0);
    check("win_board", 64'(if3.board),
          64'({2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1}));

    // Full-board tie; the last move needs all LINES scan cycles.
    start3();
    check("restart_outcome", 64'(if3.outcome), 64'd0);
    check("restart_board", 64'(if3.board), 64'd0);
    foreach (moves_tie[i]) move3(moves_tie[i]);
    repeat (8) @(negedge clk);
    check("tie_lat_early", 64'(if3.done), 64'd0);
    @(negedge clk);
    check("tie_done", 64'(if3.done), 64'd1);
    check("tie_outcome", 64'(if3.outcome), 64'd2);
    check("tie_winner", 64'(if3.winner), 64'd0);
    check("tie_board", 64'(if3.board),
          64'({2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1}));

    // Occupied and out-of-range cells are rejected without side effects.
    start3();
    move3(4);
    wait_ready3("ready_rej");
    check("rej_cur_before", 64'(if3.cur_player), 64'd1);
    move3(4);
    check("rej_pulse", 64'(if3.reject), 64'd1);
    check("rej_cur", 64'(if3.cur_player), 64'd1);
    check("rej_board", 64'(if3.board), 64'h100);
    check("rej_ready", 64'(if3.move_ready), 64'd1);
    @(negedge clk);
    check("rej_one_cycle", 64'(if3.reject), 64'd0);
    move3(9);
    check("rej_range", 64'(if3.reject), 64'd1);
    check("rej_range_board", 64'(if3.board), 64'h100);

    // Asynchronous reset in the middle of a scan.
    move3(0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_scan_ready", 64'(if3.move_ready), 64'd0);
    check("rst_scan_board", 64'(if3.board), 64'd0);
    check("rst_scan_cur", 64'(if3.cur_player), 64'd0);
    check("rst_scan_misc",
          64'({if3.outcome, if3.winner, if3.done, if3.reject, if3.timeout}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start3();
    move3(4);
    wait_ready3("ready_ign");
    start3();
    check("ign_start_cur", 64'(if3.cur_player), 64'd1);
    check("ign_start_board", 64'(if3.board), 64'h100);
    check("ign_start_ready", 64'(if3.move_ready), 64'd1);

    // 4x4, 3 players: player 0 completes the anti diagonal 3,6,9,12.
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    foreach (moves_n4[i]) move4(moves_n4[i]);
    wait_done4();
    check("n4_done", 64'(if4.done), 64'd1);
    check("n4_outcome", 64'(if4.outcome), 64'd1);
    check("n4_winner", 64'(if4.winner), 64'd1);
    check("n4_cur", 64'(if4.cur_player), 64'd0);

    // Turn limit of 16 cycles with no move presented.
    ift.start = 1'b1;
    @(negedge clk);
    ift.start = 1'b0;
    repeat (15) @(negedge clk);
    check("to_early", 64'(ift.timeout), 64'd0);
    check("to_early_ready", 64'(ift.move_ready), 64'd1);
    @(negedge clk);
    check("to_pulse", 64'(ift.timeout), 64'd1);
    check("to_cur_hold", 64'(ift.cur_player), 64'd0);
    @(negedge clk);
    check("to_one_cycle", 64'(ift.timeout), 64'd0);
    check("to_cur_next", 64'(ift.cur_player), 64'd1);
    check("to_board", 64'(ift.board), 64'd0);
    check("to_ready", 64'(ift.move_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
